gpr_file: RTL and testbench

Parametrised general-purpose register file for the CPU datapath. It generalises the original 8-bit, 11-entry register block in four ways: configurable width and depth, two write ports with fixed priority, optional write-to-read bypass, and a hardware pointer pair with atomic increment/decrement that drives the RAM address. It sits between instruction decode/ALU (write port A), the load path (write port B) and the RAM address input.

---
 rtl/gpr_file.sv | 111 +++++++++++
 tb/tb_gpr_file.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/gpr_file.sv
// gpr_file: parametrised register file with two prioritised write ports,
// optional write-to-read bypass and an inc/dec pointer register pair.
// Ports: clk/rst (sync, active-high); wa_* ALU write port; wb_* load write
// port (wins over A); ptr_op 01 inc / 10 dec; r_addr_a/b -> r_data_a/b;
// ptr_addr pointer value; ptr_wrap / wr_err one-cycle registered pulses.
module gpr_file #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16,
  parameter int PTR_REG  = 10,
  parameter int PTR_W    = 12,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [1:0]        ptr_op,
  input  logic [ADDR_W-1:0] r_addr_a,
  input  logic [ADDR_W-1:0] r_addr_b,
  output logic [DATA_W-1:0] r_data_a,
  output logic [DATA_W-1:0] r_data_b,
  output logic [PTR_W-1:0]  ptr_addr,
  output logic              ptr_wrap,
  output logic              wr_err
);

  localparam int AW1 = ADDR_W + 1;
  localparam logic [ADDR_W:0]   NR = AW1'(NUM_REGS);
  localparam logic [ADDR_W-1:0] PL = ADDR_W'(PTR_REG);
  localparam logic [ADDR_W-1:0] PH = ADDR_W'(PTR_REG + 1);

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              wa_ok;
  logic              wb_ok;
  logic              ptr_hit;
  logic              op_inc;
  logic              op_dec;
  logic              ptr_go;
  logic [PTR_W-1:0]  p;
  logic [PTR_W-1:0]  p_next;
  logic [DATA_W-1:0] pn_lo;
  logic [DATA_W-1:0] pn_hi;
  logic              p_wrap;

  assign wa_ok = wa_en && ({1'b0, wa_addr} < NR);
  assign wb_ok = wb_en && ({1'b0, wb_addr} < NR);

  // A port write to either pointer byte cancels the pointer op.
  assign ptr_hit = (wa_ok && (wa_addr == PL || wa_addr == PH))
                || (wb_ok && (wb_addr == PL || wb_addr == PH));

  assign op_inc = (ptr_op == 2'b01);
  assign op_dec = (ptr_op == 2'b10);
  assign ptr_go = (op_inc || op_dec) && !ptr_hit;

  // Upper high-byte bits are masked off here.
  assign p        = PTR_W'({regs[PTR_REG+1], regs[PTR_REG]});
  assign ptr_addr = p;

  assign p_next = op_inc ? p + 1'b1 : p - 1'b1;
  assign p_wrap = op_inc ? (&p) : ~(|p);
  assign pn_lo  = p_next[DATA_W-1:0];
  assign pn_hi  = DATA_W'(p_next >> DATA_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      ptr_wrap <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wb_ok && wb_addr == ADDR_W'(i))
          regs[i] <= wb_data;
        else if (wa_ok && wa_addr == ADDR_W'(i))
          regs[i] <= wa_data;
        else if (ptr_go && i == PTR_REG)
          regs[i] <= pn_lo;
        else if (ptr_go && i == PTR_REG + 1)
          regs[i] <= pn_hi;
      end
      ptr_wrap <= ptr_go && p_wrap;
      wr_err   <= (wa_en && !wa_ok) || (wb_en && !wb_ok);
    end
  end

  // Port B is checked last so its data wins a double bypass match.
  always_comb begin
    r_data_a = '0;
    if ({1'b0, r_addr_a} < NR) r_data_a = regs[r_addr_a];
    if (BYPASS != 0) begin
      if (wa_ok && wa_addr == r_addr_a) r_data_a = wa_data;
      if (wb_ok && wb_addr == r_addr_a) r_data_a = wb_data;
    end
  end

  always_comb begin
    r_data_b = '0;
    if ({1'b0, r_addr_b} < NR) r_data_b = regs[r_addr_b];
    if (BYPASS != 0) begin
      if (wa_ok && wa_addr == r_addr_b) r_data_b = wa_data;
      if (wb_ok && wb_addr == r_addr_b) r_data_b = wb_data;
    end
  end

endmodule

// File: tb/tb_gpr_file.sv
// tb_gpr_file: directed bench for gpr_file (11 regs, pointer at 8/9)
// with a behavioural reference model checked every cycle.
module tb_gpr_file;

  localparam int N  = 11;
  localparam int PR = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wa_en = 1'b0;
  logic [3:0] wa_addr = '0;
  logic [7:0] wa_data = '0;
  logic       wb_en = 1'b0;
  logic [3:0] wb_addr = '0;
  logic [7:0] wb_data = '0;
  logic [1:0] ptr_op = '0;
  logic [3:0] r_addr_a = '0;
  logic [3:0] r_addr_b = '0;
  logic [7:0] r_data_a;
  logic [7:0] r_data_b;
  logic [11:0] ptr_addr;
  logic       ptr_wrap;
  logic       wr_err;

  gpr_file #(
    .DATA_W(8), .ADDR_W(4), .NUM_REGS(N),
    .PTR_REG(PR), .PTR_W(12), .BYPASS(1)
  ) dut (
    .clk(clk), .rst(rst),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ptr_op(ptr_op),
    .r_addr_a(r_addr_a), .r_addr_b(r_addr_b),
    .r_data_a(r_data_a), .r_data_b(r_data_b),
    .ptr_addr(ptr_addr), .ptr_wrap(ptr_wrap), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;
  int mreg [16];
  int mwrap = 0;
  int merr  = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_rd(input int a);
    int v;
    if (a >= N) return 0;
    v = mreg[a];
    if (wa_en && int'(wa_addr) < N && int'(wa_addr) == a) v = int'(wa_data);
    if (wb_en && int'(wb_addr) < N && int'(wb_addr) == a) v = int'(wb_data);
    return v;
  endfunction

  function automatic int exp_ptr();
    return (mreg[PR+1] * 256 + mreg[PR]) % 4096;
  endfunction

  always @(posedge clk) begin : model
    int nx [16];
    int pv;
    int np;
    bit aok;
    bit bok;
    bit hit;
    if (rst) begin
      for (int i = 0; i < 16; i++) mreg[i] = 0;
      mwrap = 0;
      merr  = 0;
    end else begin
      aok = wa_en && int'(wa_addr) < N;
      bok = wb_en && int'(wb_addr) < N;
      merr = ((wa_en && !aok) || (wb_en && !bok)) ? 1 : 0;
      hit = (aok && (int'(wa_addr) == PR || int'(wa_addr) == PR + 1))
         || (bok && (int'(wb_addr) == PR || int'(wb_addr) == PR + 1));
      pv = exp_ptr();
      for (int i = 0; i < 16; i++) nx[i] = mreg[i];
      if (aok) nx[wa_addr] = int'(wa_data);
      if (bok) nx[wb_addr] = int'(wb_data);
      mwrap = 0;
      if (!hit && (ptr_op == 2'b01 || ptr_op == 2'b10)) begin
        if (ptr_op == 2'b01) begin
          np = (pv + 1) % 4096;
          mwrap = (pv == 4095) ? 1 : 0;
        end else begin
          np = (pv + 4095) % 4096;
          mwrap = (pv == 0) ? 1 : 0;
        end
        nx[PR]   = np % 256;
        nx[PR+1] = np / 256;
      end
      for (int i = 0; i < 16; i++) mreg[i] = nx[i];
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("rd_a", int'(r_data_a), exp_rd(int'(r_addr_a)));
      check("rd_b", int'(r_data_b), exp_rd(int'(r_addr_b)));
      check("ptr_addr", int'(ptr_addr), exp_ptr());
      check("ptr_wrap", int'(ptr_wrap), mwrap);
      check("wr_err", int'(wr_err), merr);
    end
  end

  task automatic drv(input bit r, input bit ae, input int aa, input int ad,
                     input bit be, input int ba, input int bd,
                     input int op, input int ra, input int rb);
    @(posedge clk);
    #1;
    rst      = r;
    wa_en    = ae;
    wa_addr  = 4'(aa);
    wa_data  = 8'(ad);
    wb_en    = be;
    wb_addr  = 4'(ba);
    wb_data  = 8'(bd);
    ptr_op   = 2'(op);
    r_addr_a = 4'(ra);
    r_addr_b = 4'(rb);
    @(negedge clk);
  endtask

  task automatic idle(input int ra, input int rb);
    drv(0, 0, 0, 0, 0, 0, 0, 0, ra, rb);
  endtask

  initial begin
    @(posedge clk);
    #1;
    cmp_on = 1'b1;
    @(negedge clk);
    check("rst_rd_a", int'(r_data_a), 0);
    check("rst_ptr", int'(ptr_addr), 0);
    check("rst_wrap", int'(ptr_wrap), 0);
    check("rst_err", int'(wr_err), 0);

    drv(0, 1, 3, 'hA5, 0, 0, 0, 0, 3, 0);
    check("byp_a5", int'(r_data_a), 'hA5);
    idle(3, 3);
    check("reg3_a5", int'(r_data_a), 'hA5);

    drv(0, 1, 5, 'h11, 1, 5, 'h22, 0, 5, 5);
    check("byp_prio", int'(r_data_b), 'h22);
    drv(0, 1, 6, 'h33, 1, 7, 'h44, 0, 5, 6);
    check("reg5_b", int'(r_data_a), 'h22);
    idle(6, 7);
    check("reg6", int'(r_data_a), 'h33);
    check("reg7", int'(r_data_b), 'h44);

    drv(0, 1, PR, 'hFF, 1, PR + 1, 'h0F, 0, PR, PR + 1);
    drv(0, 0, 0, 0, 0, 0, 0, 1, PR, PR + 1);
    check("ptr_fff", int'(ptr_addr), 'hFFF);
    check("no_ptr_byp", int'(r_data_a), 'hFF);
    drv(0, 0, 0, 0, 0, 0, 0, 2, PR, PR + 1);
    check("ptr_wrap0", int'(ptr_addr), 'h000);
    check("wrap_inc", int'(ptr_wrap), 1);
    idle(PR, PR + 1);
    check("ptr_wrapfff", int'(ptr_addr), 'hFFF);
    check("wrap_dec", int'(ptr_wrap), 1);
    check("hi_byte", int'(r_data_b), 'h0F);
    idle(PR, PR + 1);
    check("wrap_end", int'(ptr_wrap), 0);

    drv(0, 1, PR, 'hFF, 1, PR + 1, 'h00, 0, PR, PR + 1);
    drv(0, 0, 0, 0, 0, 0, 0, 1, PR, PR + 1);
    check("ptr_0ff", int'(ptr_addr), 'h0FF);
    drv(0, 1, PR, 'h40, 0, 0, 0, 1, PR, PR + 1);
    check("ptr_carry", int'(ptr_addr), 'h100);
    check("carry_nowrap", int'(ptr_wrap), 0);
    idle(PR, PR + 1);
    check("ptr_blocked", int'(ptr_addr), 'h140);
    check("blk_nowrap", int'(ptr_wrap), 0);

    drv(0, 0, 0, 0, 1, PR + 1, 'hF3, 0, PR, PR + 1);
    drv(0, 0, 0, 0, 0, 0, 0, 2, PR, PR + 1);
    check("ptr_mask", int'(ptr_addr), 'h340);
    check("hi_verbatim", int'(r_data_b), 'hF3);
    idle(PR, PR + 1);
    check("ptr_dec", int'(ptr_addr), 'h33F);
    check("hi_cleared", int'(r_data_b), 'h03);

    drv(0, 1, 12, 'h77, 1, 15, 'h88, 0, 12, 15);
    check("byp_oor", int'(r_data_a), 0);
    drv(0, 1, 11, 'h01, 0, 0, 0, 0, 12, 0);
    check("err_pulse", int'(wr_err), 1);
    check("rd_oor", int'(r_data_a), 0);
    drv(0, 0, 0, 0, 1, 13, 'h02, 0, 3, 0);
    check("err_b2b", int'(wr_err), 1);
    check("reg3_kept", int'(r_data_a), 'hA5);
    idle(3, 0);
    check("err_b2b2", int'(wr_err), 1);
    idle(3, 0);
    check("err_end", int'(wr_err), 0);

    drv(0, 0, 0, 0, 0, 0, 0, 2, 3, PR);
    drv(1, 1, 12, 'h99, 1, 4, 'h55, 1, 3, PR);
    idle(3, PR);
    check("rst_reg3", int'(r_data_a), 0);
    check("rst_regp", int'(r_data_b), 0);
    check("rst_ptr2", int'(ptr_addr), 0);
    check("rst_wrap2", int'(ptr_wrap), 0);
    check("rst_err2", int'(wr_err), 0);
    idle(4, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
